note_controller: RTL and testbench

//  Parametrised keyboard/note controller for the electronic-piano datapath.

---
 rtl/note_pkg.sv | 18 +
 rtl/key_debounce.sv | 43 ++++
 rtl/note_controller.sv | 187 ++++++++++++++++++
 tb/tb_note_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared constants and FSM encoding for the piano note controller.
package note_pkg;

    localparam logic [2:0] MODE_FREE  = 3'b100;
    localparam logic [2:0] MODE_AUTO  = 3'b010;
    localparam logic [2:0] MODE_LEARN = 3'b001;

    localparam int unsigned NOTE_REST = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FREE   = 3'd1,
        ST_AUTO   = 3'd2,
        ST_L_WAIT = 3'd3,
        ST_L_PLAY = 3'd4
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: 2-FF synchroniser followed by a stability counter.
//  clk, rst_n : clock, async active-low reset
//  key        : raw asynchronous key pin
//  stable     : debounced key level
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic stable
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // stable follows sync2 only after DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            if (sync2 != stable) begin
                if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/note_controller.sv
// Keyboard/note controller: debounces keys, resolves a note, and selects
// free-play, auto-play or learn mode (with hit/miss scoring).
//  keys        : raw key pins (key i -> note i+1)
//  mode        : 100 free, 010 auto, 001 learn, other idle
//  auto_note   : auto-play sequencer note
//  learn_note/learn_valid/learn_ready : expected-note handshake
//  note_out, led_out : tone-generator note and key LEDs
//  hit, miss   : one-cycle learn result pulses; score : saturating hit count
module note_controller
    import note_pkg::*;
#(
    parameter int unsigned N_KEYS       = 7,
    parameter int unsigned NOTE_W       = 4,
    parameter int unsigned DEBOUNCE_CYC = 20000,
    parameter int unsigned TIMEOUT_CYC  = 50000000,
    parameter int unsigned SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_KEYS-1:0]  keys,
    input  logic [2:0]         mode,
    input  logic [NOTE_W-1:0]  auto_note,
    input  logic [NOTE_W-1:0]  learn_note,
    input  logic               learn_valid,
    output logic               learn_ready,
    output logic [NOTE_W-1:0]  note_out,
    output logic [N_KEYS-1:0]  led_out,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score
);

    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [N_KEYS-1:0]  stable;
    logic [NOTE_W-1:0]  key_note;
    logic [NOTE_W-1:0]  key_note_q;
    logic               press;
    state_t             state_q, state_d, tgt;
    logic               mode_change;
    logic [NOTE_W-1:0]  exp_q, exp_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [NOTE_W-1:0]  note_d;
    logic [N_KEYS-1:0]  led_d;
    logic               hit_d, miss_d, ready_d;
    logic [SCORE_W-1:0] score_d;

    function automatic logic [N_KEYS-1:0] one_hot(input logic [NOTE_W-1:0] n);
        logic [N_KEYS-1:0] v;
        v = '0;
        for (int i = 0; i < int'(N_KEYS); i++) begin
            if (n == NOTE_W'(i + 1)) v[i] = 1'b1;
        end
        return v;
    endfunction

    for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_deb
        key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .key    (keys[g]),
            .stable (stable[g])
        );
    end

    // Exactly one stable key gives its note; none or a chord gives rest
    always_comb begin
        logic [NOTE_W-1:0] n_set;
        logic [NOTE_W-1:0] idx;
        n_set    = '0;
        idx      = '0;
        key_note = NOTE_W'(NOTE_REST);
        for (int i = 0; i < int'(N_KEYS); i++) begin
            if (stable[i]) begin
                n_set = n_set + NOTE_W'(1);
                idx   = NOTE_W'(i + 1);
            end
        end
        if (n_set == NOTE_W'(1)) key_note = idx;
    end

    // A held key is never a fresh press: only transitions to a new nonzero note count
    assign press = (key_note != NOTE_W'(NOTE_REST)) && (key_note != key_note_q);

    // Requested state for the sampled mode
    always_comb begin
        tgt = ST_IDLE;
        case (mode)
            MODE_FREE:  tgt = ST_FREE;
            MODE_AUTO:  tgt = ST_AUTO;
            MODE_LEARN: tgt = ST_L_WAIT;
            default:    tgt = ST_IDLE;
        endcase
        if (tgt == ST_L_WAIT)
            mode_change = (state_q != ST_L_WAIT) && (state_q != ST_L_PLAY);
        else
            mode_change = (state_q != tgt);
    end

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        tmo_d   = tmo_q;
        note_d  = '0;
        led_d   = '0;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        score_d = score_q_sat_hold();
        if (mode_change) begin
            state_d = tgt;
            tmo_d   = '0;
            if (tgt == ST_L_WAIT) score_d = '0;
        end else begin
            case (state_q)
                ST_FREE: begin
                    note_d = key_note;
                    led_d  = one_hot(key_note);
                end
                ST_AUTO: begin
                    if (auto_note <= NOTE_W'(N_KEYS)) begin
                        note_d = auto_note;
                        led_d  = one_hot(auto_note);
                    end
                end
                ST_L_WAIT: begin
                    note_d = key_note;
                    if (learn_valid && learn_ready) begin
                        exp_d   = (learn_note <= NOTE_W'(N_KEYS)) ? learn_note : NOTE_W'(NOTE_REST);
                        tmo_d   = '0;
                        state_d = ST_L_PLAY;
                    end
                end
                ST_L_PLAY: begin
                    note_d = key_note;
                    led_d  = one_hot(exp_q);
                    tmo_d  = tmo_q + TMO_W'(1);
                    // A correct press beats a simultaneous timeout
                    if (exp_q == NOTE_W'(NOTE_REST) || (press && key_note == exp_q)) begin
                        hit_d   = 1'b1;
                        state_d = ST_L_WAIT;
                        if (score != '1) score_d = score + SCORE_W'(1);
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        miss_d  = 1'b1;
                        state_d = ST_L_WAIT;
                    end else if (press) begin
                        miss_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        ready_d = (state_d == ST_L_WAIT);
    end

    function automatic logic [SCORE_W-1:0] score_q_sat_hold();
        return score;
    endfunction

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            exp_q       <= '0;
            tmo_q       <= '0;
            key_note_q  <= '0;
            note_out    <= '0;
            led_out     <= '0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            score       <= '0;
            learn_ready <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            tmo_q       <= tmo_d;
            key_note_q  <= key_note;
            note_out    <= note_d;
            led_out     <= led_d;
            hit         <= hit_d;
            miss        <= miss_d;
            score       <= score_d;
            learn_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_note_controller.sv
// Directed self-checking bench for note_controller (DEBOUNCE_CYC=4, TIMEOUT_CYC=32).
module tb_note_controller;

    localparam int unsigned N_KEYS  = 7;
    localparam int unsigned NOTE_W  = 4;
    localparam int unsigned SCORE_W = 8;

    logic               clk;
    logic               rst_n;
    logic [N_KEYS-1:0]  keys;
    logic [2:0]         mode;
    logic [NOTE_W-1:0]  auto_note;
    logic [NOTE_W-1:0]  learn_note;
    logic               learn_valid;
    logic               learn_ready;
    logic [NOTE_W-1:0]  note_out;
    logic [N_KEYS-1:0]  led_out;
    logic               hit;
    logic               miss;
    logic [SCORE_W-1:0] score;

    int checks   = 0;
    int failures = 0;
    int pulses;

    note_controller #(
        .N_KEYS       (N_KEYS),
        .NOTE_W       (NOTE_W),
        .DEBOUNCE_CYC (4),
        .TIMEOUT_CYC  (32),
        .SCORE_W      (SCORE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keys        (keys),
        .mode        (mode),
        .auto_note   (auto_note),
        .learn_note  (learn_note),
        .learn_valid (learn_valid),
        .learn_ready (learn_ready),
        .note_out    (note_out),
        .led_out     (led_out),
        .hit         (hit),
        .miss        (miss),
        .score       (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic handshake(input logic [NOTE_W-1:0] n);
        check_eq("ready_before_hs", 32'(learn_ready), 32'(1));
        learn_note  = n;
        learn_valid = 1'b1;
        tick(1);
        learn_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        keys        = '0;
        mode        = 3'b000;
        auto_note   = '0;
        learn_note  = '0;
        learn_valid = 1'b0;
        tick(3);
        check_eq("rst_note", 32'(note_out), 32'(0));
        check_eq("rst_led", 32'(led_out), 32'(0));
        check_eq("rst_ready", 32'(learn_ready), 32'(0));
        check_eq("rst_score", 32'(score), 32'(0));

        // 1. free play latency DEBOUNCE_CYC+3 = 7
        rst_n = 1'b1;
        mode  = 3'b100;
        keys  = 7'b0000100;
        tick(6);
        check_eq("free_lat_6", 32'(note_out), 32'(0));
        tick(1);
        check_eq("free_lat_7", 32'(note_out), 32'(3));
        check_eq("free_led", 32'(led_out), 32'(7'b0000100));
        keys = 7'b0000101;
        tick(2);
        keys = 7'b0000100;
        tick(8);
        check_eq("glitch_note", 32'(note_out), 32'(3));

        // 2. chord -> rest, then single key
        keys = 7'b0000101;
        tick(8);
        check_eq("chord_note", 32'(note_out), 32'(0));
        check_eq("chord_led", 32'(led_out), 32'(0));
        keys = 7'b0000001;
        tick(8);
        check_eq("single_note", 32'(note_out), 32'(1));
        check_eq("single_led", 32'(led_out), 32'(7'b0000001));

        // 3. auto play, keys ignored
        mode      = 3'b010;
        auto_note = 4'd5;
        tick(3);
        check_eq("auto_note5", 32'(note_out), 32'(5));
        check_eq("auto_led5", 32'(led_out), 32'(7'b0010000));
        auto_note = 4'd9;
        tick(2);
        check_eq("auto_note9", 32'(note_out), 32'(0));
        check_eq("auto_led9", 32'(led_out), 32'(0));

        // 4. learn: hit, miss, hit
        keys = '0;
        tick(8);
        mode = 3'b001;
        tick(2);
        check_eq("learn_ready", 32'(learn_ready), 32'(1));
        check_eq("learn_score0", 32'(score), 32'(0));
        handshake(4'd4);
        check_eq("play_ready", 32'(learn_ready), 32'(0));
        tick(1);
        check_eq("play_led", 32'(led_out), 32'(7'b0001000));
        keys = 7'b0001000;
        tick(6);
        check_eq("hit_early", 32'(hit), 32'(0));
        tick(1);
        check_eq("hit1", 32'(hit), 32'(1));
        check_eq("hit1_miss", 32'(miss), 32'(0));
        check_eq("score1", 32'(score), 32'(1));
        check_eq("hit1_ready", 32'(learn_ready), 32'(1));
        tick(1);
        check_eq("hit1_pulse_end", 32'(hit), 32'(0));
        keys = '0;
        tick(8);
        handshake(4'd4);
        keys = 7'b0000010;
        tick(7);
        check_eq("wrong_miss", 32'(miss), 32'(1));
        check_eq("wrong_hit", 32'(hit), 32'(0));
        keys = 7'b0001000;
        tick(7);
        check_eq("hit2", 32'(hit), 32'(1));
        check_eq("score2", 32'(score), 32'(2));

        // 5. timeout then rest note
        keys = '0;
        tick(8);
        handshake(4'd2);
        tick(31);
        check_eq("tmo_early", 32'(miss), 32'(0));
        tick(1);
        check_eq("tmo_miss", 32'(miss), 32'(1));
        check_eq("tmo_hit", 32'(hit), 32'(0));
        check_eq("tmo_ready", 32'(learn_ready), 32'(1));
        check_eq("tmo_score", 32'(score), 32'(2));
        tick(1);
        check_eq("tmo_pulse_end", 32'(miss), 32'(0));
        handshake(4'd0);
        tick(1);
        check_eq("rest_hit", 32'(hit), 32'(1));
        tick(1);
        check_eq("rest_pulse_end", 32'(hit), 32'(0));
        check_eq("rest_ready", 32'(learn_ready), 32'(1));

        // 6a. async reset in L_PLAY
        keys = 7'b0000001;
        tick(8);
        handshake(4'd3);
        tick(2);
        check_eq("pre_rst_led", 32'(led_out), 32'(7'b0000100));
        check_eq("pre_rst_note", 32'(note_out), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_note", 32'(note_out), 32'(0));
        check_eq("async_led", 32'(led_out), 32'(0));
        check_eq("async_score", 32'(score), 32'(0));
        check_eq("async_ready", 32'(learn_ready), 32'(0));
        keys = '0;
        tick(2);
        rst_n = 1'b1;

        // 6b. mode change mid-note: no pulses, score cleared on re-entry
        tick(3);
        handshake(4'd1);
        keys = 7'b0000001;
        tick(7);
        check_eq("re_hit", 32'(hit), 32'(1));
        check_eq("re_score1", 32'(score), 32'(1));
        keys = '0;
        tick(8);
        handshake(4'd2);
        keys = 7'b0000010;
        tick(3);
        mode   = 3'b100;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (hit || miss) pulses++;
        end
        check_eq("abort_pulses", 32'(pulses), 32'(0));
        check_eq("abort_free_note", 32'(note_out), 32'(2));
        check_eq("abort_ready", 32'(learn_ready), 32'(0));
        mode = 3'b001;
        tick(2);
        check_eq("reentry_score", 32'(score), 32'(0));
        check_eq("reentry_ready", 32'(learn_ready), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
